// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, STATUS/CTRL bit indices and FSM state encodings
package uart_apb_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_BAUD   = 4'hC;

    localparam int STAT_TX_EMPTY  = 0;
    localparam int STAT_TX_FULL   = 1;
    localparam int STAT_RX_EMPTY  = 2;
    localparam int STAT_RX_FULL   = 3;
    localparam int STAT_TX_OVF    = 4;
    localparam int STAT_RX_OVR    = 5;
    localparam int STAT_FRAME_ERR = 6;
    localparam int STAT_PARITY_ERR = 7;

    localparam int CTRL_PAR_EN  = 0;
    localparam int CTRL_PAR_ODD = 1;
    localparam int CTRL_STOP2   = 2;
    localparam int CTRL_IE_RX   = 3;
    localparam int CTRL_IE_TX   = 4;
    localparam int CTRL_IE_ERR  = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with first-word fall-through head
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_apb_fifo.sv
// rtl/uart_apb_fifo.sv - APB-mapped UART with TX/RX FIFOs, parity, sticky errors and IRQ
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RESET = 16'd53
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        pSel,
    input  logic        pEnable,
    input  logic        pWrite,
    input  logic [31:0] pAddr,
    input  logic [31:0] pWdata,
    output logic [31:0] pReadData,
    input  logic        RxD,
    output logic        TxD,
    output logic        IRQ
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]  addr;
    logic        access, wr_data, rd_data, wr_status, wr_ctrl, wr_baud;
    logic [5:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d, baud_cnt_q, baud_cnt_d;
    logic [3:0]  sticky_q, sticky_d;
    logic        irq_q, irq_d, tick;

    logic                 tx_empty, tx_full, tx_pop;
    logic [DATA_BITS-1:0] tx_dout;
    logic [CW-1:0]        tx_count;
    logic                 rx_empty, rx_full, rx_push, rx_pop;
    logic [DATA_BITS-1:0] rx_dout;
    logic [CW-1:0]        rx_count;
    logic [31:0]          rx_count_ext, status;

    uart_state_e          tx_state_q, tx_state_d;
    logic [4:0]           tx_cnt_q, tx_cnt_d, tx_last;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_load;

    uart_state_e          rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
    logic                 frame_set, par_set;
    logic                 unused_bits;

    assign addr      = pAddr[3:0];
    assign access    = pSel & pEnable;
    assign wr_data   = access & pWrite & (addr == REG_DATA);
    assign rd_data   = access & ~pWrite & (addr == REG_DATA);
    assign wr_status = access & pWrite & (addr == REG_STATUS);
    assign wr_ctrl   = access & pWrite & (addr == REG_CTRL);
    assign wr_baud   = access & pWrite & (addr == REG_BAUD);
    assign rx_pop    = rd_data & ~rx_empty;
    assign tick      = (baud_cnt_q == 16'd0);
    assign rx_fall   = rx_prev_q & ~rx_s2_q;
    assign TxD       = txd_q;
    assign IRQ       = irq_q;
    assign rx_count_ext = 32'(rx_count);
    assign unused_bits  = ^{pAddr[31:4], pWdata[31:16], rx_count_ext[31:8], tx_count};

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pClk), .reset(pReset), .push(wr_data), .push_data(pWdata[DATA_BITS-1:0]),
        .pop(tx_pop), .pop_data(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pClk), .reset(pReset), .push(rx_push), .push_data(rx_shift_q),
        .pop(rx_pop), .pop_data(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        status = '0;
        status[STAT_TX_EMPTY]   = tx_empty;
        status[STAT_TX_FULL]    = tx_full;
        status[STAT_RX_EMPTY]   = rx_empty;
        status[STAT_RX_FULL]    = rx_full;
        status[STAT_TX_OVF +: 4] = sticky_q;
        status[23:16]           = rx_count_ext[7:0];
        pReadData = '0;
        if (pSel) begin
            case (addr)
                REG_DATA:   pReadData = rx_empty ? 32'd0 : 32'(rx_dout);
                REG_STATUS: pReadData = status;
                REG_CTRL:   pReadData = 32'(ctrl_q);
                REG_BAUD:   pReadData = 32'(baud_q);
                default:    pReadData = '0;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = wr_ctrl ? pWdata[5:0] : ctrl_q;
        baud_d     = wr_baud ? pWdata[15:0] : baud_q;
        baud_cnt_d = wr_baud ? pWdata[15:0] : (tick ? baud_q : baud_cnt_q - 16'd1);
        sticky_d   = sticky_q & ~(wr_status ? pWdata[7:4] : 4'd0);
        sticky_d   = sticky_d | {par_set, frame_set,
                                 rx_push & rx_full & ~rx_pop,
                                 wr_data & tx_full & ~tx_pop};
        irq_d      = (ctrl_q[CTRL_IE_RX] & ~rx_empty) | (ctrl_q[CTRL_IE_TX] & tx_empty) |
                     (ctrl_q[CTRL_IE_ERR] & (|sticky_q));
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        tx_last    = (tx_state_q == S_STOP && ctrl_q[CTRL_STOP2]) ? 5'd31 : 5'd15;
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 5'd1;
            case (tx_state_q)
                S_IDLE: begin
                    tx_cnt_d = '0;
                    tx_load  = ~tx_empty;
                end
                S_START: if (tx_cnt_q == tx_last) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    txd_d      = tx_shift_q[0];
                end
                S_DATA: if (tx_cnt_q == tx_last) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'(DATA_BITS - 1)) begin
                        tx_state_d = ctrl_q[CTRL_PAR_EN] ? S_PARITY : S_STOP;
                        txd_d      = ctrl_q[CTRL_PAR_EN] ? tx_par_q : 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
                S_PARITY: if (tx_cnt_q == tx_last) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end
                S_STOP: if (tx_cnt_q == tx_last) begin
                    tx_state_d = S_IDLE;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                    tx_load    = ~tx_empty;
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
        // Back-to-back characters load straight from STOP so there is no idle gap
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_dout;
            tx_par_d   = calc_parity(8'(tx_dout), ctrl_q[CTRL_PAR_ODD]);
            txd_d      = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = S_START;
            end
            S_START: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd7) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_idx_d   = rx_idx_q + 3'd1;
                    if (rx_idx_q == 3'(DATA_BITS - 1))
                        rx_state_d = ctrl_q[CTRL_PAR_EN] ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_cnt_d   = '0;
                    par_set    = rx_s2_q ^ calc_parity(8'(rx_shift_q), ctrl_q[CTRL_PAR_ODD]);
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: if (tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
                if (rx_cnt_q == 4'd15) begin
                    rx_push    = 1'b1;
                    frame_set  = ~rx_s2_q;
                    rx_state_d = S_IDLE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            ctrl_q     <= '0;
            baud_q     <= BAUD_RESET;
            baud_cnt_q <= BAUD_RESET;
            sticky_q   <= '0;
            irq_q      <= 1'b0;
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            baud_cnt_q <= baud_cnt_d;
            sticky_q   <= sticky_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= RxD;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

endmodule

// File: tb/tb_uart_apb_fifo.sv
// tb/tb_uart_apb_fifo.sv - register vector table plus directed loopback, overflow, parity, error and reset sequences
module tb_uart_apb_fifo;

    logic        clk = 1'b0;
    logic        rst, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata, rd;
    logic        rxd, rxd_drv, txd, irq, loop_en, found;
    int          checks = 0;
    int          failures = 0;
    int          lowc;

    always #5 clk = ~clk;
    assign rxd = loop_en ? txd : rxd_drv;

    uart_apb_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .BAUD_RESET(16'd53)) dut (
        .pClk(clk), .pReset(rst), .pSel(psel), .pEnable(penable), .pWrite(pwrite),
        .pAddr(paddr), .pWdata(pwdata), .pReadData(prdata), .RxD(rxd), .TxD(txd), .IRQ(irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); penable = 1'b1;
        #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                              input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (64) @(negedge clk);
        end
        if (with_par) begin
            rxd_drv = par_bit;
            repeat (64) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (64) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic wait_txd_low(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (txd === 1'b0) seen = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rxd_drv = 1'b1; loop_en = 1'b0;
        vecs[0]  = '{1'b0, 32'h04, 32'h0,        32'h00000005};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        32'h00000000};
        vecs[2]  = '{1'b0, 32'h0C, 32'h0,        32'd53};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,        32'h00000000};
        vecs[4]  = '{1'b0, 32'h01, 32'h0,        32'h00000000};
        vecs[5]  = '{1'b1, 32'h08, 32'h0000003F, 32'h0};
        vecs[6]  = '{1'b0, 32'h08, 32'h0,        32'h0000003F};
        vecs[7]  = '{1'b1, 32'h08, 32'hFFFFFFC5, 32'h0};
        vecs[8]  = '{1'b0, 32'h08, 32'h0,        32'h00000005};
        vecs[9]  = '{1'b1, 32'h0C, 32'hABCD1234, 32'h0};
        vecs[10] = '{1'b0, 32'h0C, 32'h0,        32'h00001234};
        vecs[11] = '{1'b1, 32'h04, 32'h000000FF, 32'h0};
        vecs[12] = '{1'b0, 32'h14, 32'h0,        32'h00000005};
        vecs[13] = '{1'b1, 32'h08, 32'h00000000, 32'h0};
        vecs[14] = '{1'b0, 32'h18, 32'h0,        32'h00000000};
        vecs[15] = '{1'b1, 32'h0C, 32'h00000003, 32'h0};
        vecs[16] = '{1'b0, 32'h0C, 32'h0,        32'h00000003};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                apb_read(vecs[i].addr, rd);
                check($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end
        paddr = 32'h0C;
        #1 check("rdata_idle_zero", prdata, 32'h0);

        apb_write(32'h8, 32'h10);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);
        apb_write(32'h8, 32'h00);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);

        loop_en = 1'b1;
        apb_write(32'h0, 32'hA5);
        apb_write(32'h0, 32'h5A);
        wait_txd_low(found);
        check("loop_start_seen", 32'(found), 32'd1);
        lowc = 0;
        while (txd === 1'b0 && lowc < 1000) begin
            lowc++;
            @(negedge clk);
        end
        check("loop_start_len", 32'(lowc), 32'd64);
        repeat (639 - 64) @(negedge clk);
        check("loop_stop_bit", 32'(txd), 32'd1);
        @(negedge clk);
        check("loop_frame_640", 32'(txd), 32'd0);
        apb_read(32'h4, rd);
        check("loop_rx_count", (rd >> 16) & 32'hFF, 32'd1);
        repeat (700) @(negedge clk);
        apb_read(32'h0, rd);
        check("loop_data0", rd, 32'hA5);
        apb_read(32'h0, rd);
        check("loop_data1", rd, 32'h5A);
        apb_read(32'h4, rd);
        check("loop_status_after", rd, 32'h5);
        loop_en = 1'b0;

        do_reset();
        apb_write(32'hC, 32'hFFFF);
        for (int i = 0; i < 5; i++) apb_write(32'h0, 32'(i + 1));
        apb_read(32'h4, rd);
        check("ovf_status", rd, 32'h16);
        apb_write(32'h4, 32'h10);
        apb_read(32'h4, rd);
        check("ovf_w1c", rd, 32'h06);

        do_reset();
        apb_write(32'hC, 32'h3);
        apb_write(32'h8, 32'h23);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        apb_read(32'h4, rd);
        check("par_good_status", rd, 32'h00010001);
        apb_read(32'h0, rd);
        check("par_good_data", rd, 32'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        apb_read(32'h4, rd);
        check("par_bad_status", rd, 32'h00010081);
        check("par_bad_irq", 32'(irq), 32'd1);
        apb_read(32'h0, rd);
        check("par_bad_data", rd, 32'h3C);
        apb_write(32'h4, 32'h80);
        repeat (2) @(negedge clk);
        check("par_irq_clear", 32'(irq), 32'd0);

        apb_write(32'h8, 32'h0);
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk);
        apb_read(32'h4, rd);
        check("glitch_no_push", rd, 32'h5);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        apb_read(32'h4, rd);
        check("frame_err_status", rd, 32'h00010041);
        apb_read(32'h0, rd);
        check("frame_err_data", rd, 32'h81);

        loop_en = 1'b1;
        apb_write(32'hC, 32'h3);
        apb_write(32'h0, 32'h00);
        apb_write(32'h0, 32'h00);
        wait_txd_low(found);
        check("rst_start_seen", 32'(found), 32'd1);
        repeat (288) @(negedge clk);
        check("rst_txd_in_bit3", 32'(txd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_txd_high", 32'(txd), 32'd1);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        apb_read(32'h4, rd);
        check("rst_fifos_empty", rd, 32'h5);
        apb_read(32'hC, rd);
        check("rst_baud", rd, 32'd53);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_apb_fifo.md
UART_APB_FIFO -- requirements
Module: uart_apb_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning character length; legal values 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX and RX FIFO entries; power of two, 4..256.
REQ-003 SHALL have parameter BAUD_RESET, default 16'd53, meaning the reset value of the BAUD divisor.
REQ-004 SHALL have port pClk, input, 1 bit: the single clock.
REQ-005 SHALL have port pReset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports pSel, pEnable and pWrite, each input, 1 bit: APB control.
REQ-007 SHALL have ports pAddr and pWdata, each input, 32 bits: APB address and write data.
REQ-008 SHALL have port pReadData, output, 32 bits: APB read data.
REQ-009 SHALL have port RxD, input, 1 bit: serial input, asynchronous to pClk.
REQ-010 SHALL have port TxD, output, 1 bit: serial output, idle high.
REQ-011 SHALL have port IRQ, output, 1 bit: level interrupt.

Function
REQ-012 SHALL treat pSel&pEnable as an access; zero wait states; decode pAddr[3:0] only.
REQ-013 SHALL drive pReadData combinationally from the address while pSel=1, and 0 otherwise.
REQ-014 SHALL implement DATA at 0x0: a write pushes pWdata[DATA_BITS-1:0] to TX FIFO; a read returns RX FIFO head zero-extended (0 if empty) and pops it once per access.
REQ-015 SHALL implement read-only STATUS at 0x4: bit0 TX_EMPTY, bit1 TX_FULL, bit2 RX_EMPTY, bit3 RX_FULL, bits4-7 sticky TX_OVF/RX_OVR/FRAME_ERR/PARITY_ERR, bits[23:16] RX count.
REQ-016 SHALL clear STATUS sticky bits by writing 1 to the same bit positions at 0x4 (W1C).
REQ-017 SHALL implement CTRL at 0x8: bit0 PAR_EN, bit1 PAR_ODD, bit2 STOP2, bit3 IE_RX (RX non-empty), bit4 IE_TX (TX empty), bit5 IE_ERR (any sticky bit).
REQ-018 SHALL implement BAUD at 0xC, bits[15:0], generating one oversample tick every BAUD+1 pClk cycles; 16 ticks make one bit time.
REQ-019 SHALL drop a DATA write while TX FIFO is full and set TX_OVF.
REQ-020 SHALL drop a received character while RX FIFO is full and set RX_OVR; FIFO contents remain unchanged.
REQ-021 SHALL implement the TX FSM IDLE->START->DATA->PARITY->STOP->IDLE: pop on the first tick at which it is IDLE and the FIFO is non-empty; drive each phase for 16 ticks, LSB first; skip PARITY when PAR_EN=0; hold STOP for 32 ticks when STOP2=1; on return to IDLE, start the next character with no idle gap if data is pending.
REQ-022 SHALL generate parity as XOR of the data bits when PAR_ODD=0, and its inverse when PAR_ODD=1.
REQ-023 SHALL synchronise RxD through two flops before any use.
REQ-024 SHALL implement the RX FSM IDLE->START->DATA->PARITY->STOP->IDLE.
REQ-025 SHALL have the RX FSM leave IDLE on a synchronised falling edge.
REQ-026 SHALL have the RX FSM return to IDLE without pushing if the line is high at tick 8 of START (glitch reject).
REQ-027 SHALL sample each data and parity bit at tick 8 of that bit.
REQ-028 SHALL on a low stop sample set FRAME_ERR, still push the character, and return to IDLE.
REQ-029 SHALL on a parity mismatch set PARITY_ERR and still push the character.
REQ-030 SHALL push to RX FIFO exactly once per frame, at the stop-bit sample.
REQ-031 SHALL apply simultaneous push and pop on a FIFO in the same cycle, including when full or empty (count unchanged, valid when full).
REQ-032 SHALL reload the baud counter on a write to BAUD; a frame in flight continues at the new rate.
REQ-033 SHALL set IRQ = (IE_RX&!RX_EMPTY)|(IE_TX&TX_EMPTY)|(IE_ERR&|sticky), registered, one cycle after the cause.

Reset
REQ-034 SHALL on pReset set TxD=1, IRQ=0, both FSMs IDLE, both FIFOs empty, sticky bits 0, CTRL=0, BAUD=BAUD_RESET, and synchroniser flops to 1.
REQ-035 SHALL on a reset asserted mid-frame abort the frame immediately; TxD is high on the next cycle and no partial character is pushed.

Structure
REQ-036 SHALL place register offsets, STATUS/CTRL bit indices and FSM state encodings in shared package uart_apb_pkg.
REQ-037 SHALL instantiate sub-module uart_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count) twice, for TX and RX.

Verification
REQ-038 SHALL cover reset: read all registers -> STATUS=0x00000005, CTRL=0, BAUD=53, TxD=1, IRQ=0.
REQ-039 SHALL cover loopback (TxD->RxD), BAUD=3, 8N1: write 0xA5 -> TxD low for 64 cycles, frame 640 cycles, RX count 1, DATA read 0xA5.
REQ-040 SHALL cover overflow, FIFO_DEPTH=4: write 5 bytes with TX stalled by BAUD=0xFFFF -> TX_FULL=1, TX_OVF=1; W1C 0x10 -> TX_OVF=0.
REQ-041 SHALL cover parity: PAR_EN=1, PAR_ODD=1; drive a frame with wrong parity for 0x3C -> PARITY_ERR=1, IRQ=1 with IE_ERR; DATA reads 0x3C.
REQ-042 SHALL cover errors: a 4-tick low glitch on RxD -> no push; a frame with stop=0 -> FRAME_ERR=1.
REQ-043 SHALL cover reset mid-frame: pReset during DATA bit 3 -> TxD=1 next cycle, FIFOs empty, no RX push.
